// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART-to-bus bridge: FSM states,
// frame command bytes and the fixed bus access size.
package uart_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    RDWAIT,
    SEND,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_PEND,
    SND_RISE,
    SND_FALL
  } snd_state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] ACK_BYTE    = 8'h06;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// UART byte stream plus data-bus signals of the bridge; master = bridge side,
// slave = UART/bus environment side.
interface uart_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_funct3;
  logic        bus_write;
  logic [31:0] bus_rdata;

  modport master (
    input  rx_data, rx_valid, tx_busy, bus_rdata,
    output tx_data, tx_start, bus_req, bus_addr, bus_wdata, bus_funct3, bus_write
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, bus_rdata,
    input  tx_data, tx_start, bus_req, bus_addr, bus_wdata, bus_funct3, bus_write
  );
endinterface

// File: rtl/uart_byte_sender.sv
// Issues one tx_start per accepted byte, only while tx_busy is low, and reports
// done once the transmitter has gone busy and returned idle.
module uart_byte_sender
  import uart_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  snd_state_t state_reg, state_next;
  logic [7:0] data_reg;
  logic       accept;

  // done only depends on state and tx_busy, so a caller may chain the next start off it
  assign done     = (state_reg == SND_FALL) && !tx_busy;
  assign tx_start = (state_reg == SND_PEND) && !tx_busy;
  assign tx_data  = data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= SND_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      SND_IDLE: if (start) begin
        accept     = 1'b1;
        state_next = SND_PEND;
      end
      SND_PEND: if (!tx_busy) state_next = SND_RISE;
      SND_RISE: if (tx_busy)  state_next = SND_FALL;
      SND_FALL: if (!tx_busy) begin
        if (start) begin
          accept     = 1'b1;
          state_next = SND_PEND;
        end else begin
          state_next = SND_IDLE;
        end
      end
      default:  state_next = SND_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_reg <= '0;
    else if (accept) data_reg <= byte_in;
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus master: 'W'/'R' frames become word writes/reads on the data bus.
// Optional macro UART_BUS_MASTER_ECHO_ACK_EN echoes 0x06 after every write.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RD_WAIT        = 2
) (
  input  logic                clk,
  input  logic                rst,
  uart_bus_master_if.master   io
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RD_W = $clog2(RD_WAIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(RD_WAIT - 1);

  state_t          state_reg, state_next;
  logic            cmd_write_reg;
  logic [1:0]      byte_cnt_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [RD_W-1:0] wait_cnt_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     wdata_reg;
  logic [31:0]     rdata_reg;

  logic            send_start;
  logic [7:0]      send_byte;
  logic            send_done;
  logic            snd_tx_start;
  logic [7:0]      snd_tx_data;
  logic [1:0]      byte_sel;
  logic            timed_out;

  assign byte_sel  = byte_cnt_reg + 2'd1;
  assign timed_out = !io.rx_valid && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    send_start = 1'b0;
    send_byte  = rdata_reg[7:0];
    case (state_reg)
      IDLE:   if (io.rx_valid && is_command(io.rx_data)) state_next = ADDR;
      ADDR: begin
        if (io.rx_valid && byte_cnt_reg == 2'd3) state_next = cmd_write_reg ? DATA : RDWAIT;
        else if (timed_out)                      state_next = IDLE;
      end
      DATA: begin
        if (io.rx_valid && byte_cnt_reg == 2'd3) state_next = WRITE;
        else if (timed_out)                      state_next = IDLE;
      end
`ifdef UART_BUS_MASTER_ECHO_ACK_EN
      WRITE: begin
        send_start = 1'b1;
        send_byte  = ACK_BYTE;
        state_next = ACK;
      end
      ACK:    if (send_done) state_next = IDLE;
`else
      WRITE:  state_next = IDLE;
`endif
      RDWAIT: if (wait_cnt_reg == RD_LAST) begin
        // first byte goes straight from the bus; the rest come from rdata_reg
        send_start = 1'b1;
        send_byte  = io.bus_rdata[7:0];
        state_next = SEND;
      end
      SEND:   if (send_done) begin
        if (byte_cnt_reg == 2'd3) begin
          state_next = IDLE;
        end else begin
          send_start = 1'b1;
          send_byte  = rdata_reg[{byte_sel, 3'b000} +: 8];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_write_reg <= 1'b0;
      byte_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      wait_cnt_reg  <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
    end else begin
      if (io.rx_valid || !(state_reg == ADDR || state_reg == DATA)) to_cnt_reg <= '0;
      else                                                          to_cnt_reg <= to_cnt_reg + 1'b1;

      if (state_reg == RDWAIT) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                     wait_cnt_reg <= '0;

      if (state_reg == RDWAIT && wait_cnt_reg == RD_LAST) rdata_reg <= io.bus_rdata;

      case (state_reg)
        IDLE: if (io.rx_valid && is_command(io.rx_data)) begin
          cmd_write_reg <= (io.rx_data == CMD_WRITE);
          byte_cnt_reg  <= '0;
        end
        ADDR: if (io.rx_valid) begin
          addr_reg[{byte_cnt_reg, 3'b000} +: 8] <= io.rx_data;
          byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
        DATA: if (io.rx_valid) begin
          wdata_reg[{byte_cnt_reg, 3'b000} +: 8] <= io.rx_data;
          byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
        SEND: if (send_done) byte_cnt_reg <= byte_cnt_reg + 2'd1;
        default: ;
      endcase
    end
  end

  uart_byte_sender u_sender (
    .clk      (clk),
    .rst      (rst),
    .start    (send_start),
    .byte_in  (send_byte),
    .tx_busy  (io.tx_busy),
    .tx_start (snd_tx_start),
    .tx_data  (snd_tx_data),
    .done     (send_done)
  );

  assign io.tx_start   = snd_tx_start;
  assign io.tx_data    = snd_tx_data;
  assign io.bus_req    = (state_reg == WRITE) || (state_reg == RDWAIT);
  assign io.bus_write  = (state_reg == WRITE);
  assign io.bus_addr   = addr_reg;
  assign io.bus_wdata  = wdata_reg;
  assign io.bus_funct3 = FUNCT3_WORD;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: frames push expected bus writes, bus_req
// burst lengths and tx bytes; monitors pop and compare as the DUT produces them.
module tb_uart_bus_master;

  localparam int TO_CYC = 40;
  localparam int RDW    = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_bus_master_if ifc ();

  uart_bus_master #(.TIMEOUT_CYCLES(TO_CYC), .RD_WAIT(RDW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  wr_t         wr_exp[$];
  logic [7:0]  tx_exp[$];
  int          req_exp[$];
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          tx_unexp  = 0;
  int          bus_unexp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // UART transmitter model: busy rises one cycle after tx_start, lasts 6 cycles
  initial begin
    int  busy_cnt;
    logic start_seen;
    busy_cnt   = 0;
    start_seen = 1'b0;
    ifc.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && ifc.tx_start) begin
        check_eq("tx_busy_low", 32'(ifc.tx_busy), 32'd0);
        if (tx_exp.size() == 0) tx_unexp++;
        else check_eq("tx_byte", 32'(ifc.tx_data), 32'(tx_exp.pop_front()));
      end
      if (start_seen) begin
        ifc.tx_busy = 1'b1;
        busy_cnt    = 6;
        start_seen  = 1'b0;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
        if (busy_cnt == 0) ifc.tx_busy = 1'b0;
      end
      if (!rst && ifc.tx_start) start_seen = 1'b1;
    end
  end

  // Bus monitor: bus_write contents and length of each bus_req burst
  initial begin
    int req_run;
    wr_t e;
    req_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_run = 0;
      end else begin
        if (ifc.bus_write) begin
          if (wr_exp.size() == 0) begin
            bus_unexp++;
          end else begin
            e = wr_exp.pop_front();
            check_eq("wr_addr",   ifc.bus_addr,  e.addr);
            check_eq("wr_data",   ifc.bus_wdata, e.data);
            check_eq("wr_funct3", 32'(ifc.bus_funct3), 32'd2);
            check_eq("wr_req",    32'(ifc.bus_req), 32'd1);
          end
        end
        if (ifc.bus_req) begin
          req_run++;
        end else if (req_run != 0) begin
          if (req_exp.size() == 0) bus_unexp++;
          else check_eq("req_len", 32'(req_run), 32'(req_exp.pop_front()));
          req_run = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic write_frame(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    wr_exp.push_back(e);
    req_exp.push_back(1);
`ifdef UART_BUS_MASTER_ECHO_ACK_EN
    tx_exp.push_back(8'h06);
`endif
    send_byte(8'h57);
    send_word(addr);
    send_word(data);
  endtask

  task automatic read_frame(input logic [31:0] addr, input logic [31:0] rdata);
    ifc.bus_rdata = rdata;
    req_exp.push_back(RDW);
    for (int i = 0; i < 4; i++) tx_exp.push_back(rdata[8*i +: 8]);
    send_byte(8'h52);
    send_word(addr);
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((tx_exp.size() + wr_exp.size() + req_exp.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check_eq(tag, 32'(tx_exp.size() + wr_exp.size() + req_exp.size()), 32'd0);
  endtask

  task automatic wait_tx_left(input int left);
    int n;
    n = 0;
    while (tx_exp.size() > left && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_progress", 32'(tx_exp.size()), 32'(left));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_start"},  32'(ifc.tx_start),   32'd0);
    check_eq({tag, "_tx_data"},   32'(ifc.tx_data),    32'd0);
    check_eq({tag, "_bus_req"},   32'(ifc.bus_req),    32'd0);
    check_eq({tag, "_bus_write"}, 32'(ifc.bus_write),  32'd0);
    check_eq({tag, "_bus_addr"},  ifc.bus_addr,        32'd0);
    check_eq({tag, "_bus_wdata"}, ifc.bus_wdata,       32'd0);
    check_eq({tag, "_funct3"},    32'(ifc.bus_funct3), 32'd2);
  endtask

  initial begin
    ifc.rx_data   = 8'h00;
    ifc.rx_valid  = 1'b0;
    ifc.bus_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // basic write
    write_frame(32'h0000_0010, 32'hDEAD_BEEF);
    wait_quiet("write_drain");
    check_eq("addr_hold",  ifc.bus_addr,  32'h0000_0010);
    check_eq("wdata_hold", ifc.bus_wdata, 32'hDEAD_BEEF);

    // basic read
    read_frame(32'h0000_0010, 32'h1234_5678);
    wait_quiet("read_drain");

    // junk byte before a write frame
    send_byte(8'h41);
    write_frame(32'h0000_0020, 32'hCAFE_F00D);
    wait_quiet("junk_drain");

    // partial frame then silence past the timeout, then a good frame
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    repeat (TO_CYC + 20) @(negedge clk);
    check_eq("to_no_write", 32'(bus_unexp), 32'd0);
    write_frame(32'h0000_0104, 32'h0102_0304);
    wait_quiet("timeout_drain");

    // rx byte during SEND is dropped; next write unaffected
    read_frame(32'h0000_0200, 32'h0BAD_F00D);
    wait_tx_left(3);
    send_byte(8'h57);
    wait_quiet("drop_drain");
    write_frame(32'h0000_0300, 32'h5555_AAAA);
    wait_quiet("after_drop_drain");

    // reset during SEND after two bytes
    read_frame(32'h0000_0400, 32'hA1B2_C3D4);
    wait_tx_left(2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tx_exp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_send_rst");
    repeat (60) @(negedge clk);
    check_eq("rst_tx_quiet", 32'(ifc.tx_start), 32'd0);

    check_eq("tx_extra",  32'(tx_unexp),  32'd0);
    check_eq("bus_extra", 32'(bus_unexp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
